reg_file_gen: RTL and testbench
===============================

Name: reg_file_gen

Overview:
- Parametrised next-generation CPU register file.
- Holds the architectural registers ACC, X, Y, FR, SP and PC, plus optional general-purpose registers.
- Provides one write port, two read ports, PC auto-increment, SP push/pop with sticky overflow/underflow detection, and a dedicated flag-update path from the ALU.
- Sits between the control unit, the ALU and the memory interface of the 16-bit processor.

Parameters:
- DATA_W, 16: register width in bits.
- NUM_REGS, 8: number of register slots; minimum 6. Slots 6..NUM_REGS-1 are general-purpose.
- FLAG_W, 4: width of FR; must be ≤ DATA_W.
- SP_INIT, all-ones (DATA_W bits): SP value after reset; the stack grows downward.
- PC_INIT, 0: PC value after reset.
- SEL_W, $clog2(NUM_REGS): width of the select fields (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  explicit write strobe.
- wr_sel  in  SEL_W  write register index.
- wr_data  in  DATA_W  write data.
- rd_a_en  in  1  read port A output enable.
- rd_a_sel  in  SEL_W  read port A index.
- rd_a_data  out  DATA_W  read port A data; high-Z when rd_a_en=0.
- rd_b_sel  in  SEL_W  read port B index (always driven).
- rd_b_data  out  DATA_W  read port B data.
- pc_inc  in  1  increment PC by 1.
- sp_op  in  2  stack operation: 00 none, 01 push (SP-1), 10 pop (SP+1), 11 reserved (no-op).
- flags_we  in  1  load FR from flags_in.
- flags_in  in  FLAG_W  ALU flags.
- sp_ovf  out  1  sticky: push attempted while SP=0.
- sp_unf  out  1  sticky: pop attempted while SP=all-ones.
- acc_out, x_out, y_out, sp_out, pc_out  out  DATA_W each  direct register views.
- fr_out  out  FLAG_W  direct FR view.

Behaviour:
- Register map: 0=ACC, 1=X, 2=Y, 3=FR, 4=SP, 5=PC, 6+ = general-purpose.
- Reset (async, immediate on rst rising, held while rst=1):
  - all registers 0, except SP=SP_INIT and PC=PC_INIT;
  - sp_ovf=0, sp_unf=0;
  - rd_b_data reflects the reset contents.
- Explicit write: on the clock edge with wr_en=1 and wr_sel<NUM_REGS, the selected register takes wr_data.
  - FR takes wr_data[FLAG_W-1:0].
  - wr_sel≥NUM_REGS: write ignored.
- Write priority, same edge:
  - explicit write to PC overrides pc_inc;
  - explicit write to SP overrides sp_op;
  - explicit write to FR overrides flags_we.
  - Non-conflicting operations in the same cycle all take effect, e.g. a write to X, pc_inc, push and flags_we together.
- PC: pc_inc adds 1 modulo 2^DATA_W; all-ones wraps to 0 with no flag.
- SP push:
  - SP≠0: SP←SP-1.
  - SP=0: SP unchanged and sp_ovf←1.
- SP pop:
  - SP≠all-ones: SP←SP+1.
  - SP=all-ones: SP unchanged and sp_unf←1.
- Sticky flags: sp_ovf and sp_unf clear only on reset or on an explicit write to SP. That write clears both flags on the same edge, even if sp_op also signals an error in that cycle.
- Reads (combinational, zero latency):
  - contents as of the last edge;
  - FR is zero-extended to DATA_W;
  - sel≥NUM_REGS returns 0.
  - Port A drives high-Z when rd_a_en=0. Port B has no enable.
- Direct view outputs always show current register contents.
- No internal FSM beyond the register state.
- Never generate latches. Use no X values on outputs after reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Both read ports are write-first. When wr_en=1, wr_sel<NUM_REGS and wr_sel equals the read index, the port returns wr_data (FR: zero-extended wr_data[FLAG_W-1:0]) in the same cycle.
  - Bypass covers the explicit write only, not pc_inc, sp_op or flags_we.
  - Port A's high-Z rule still applies.
- Undefined: reads always return stored contents (read-first), exactly as described in Behaviour.

Test Plan:
- Reset: assert rst mid-cycle after writing ACC=0x1234 → outputs update immediately without waiting for a clock edge: acc_out=0, sp_out=0xFFFF, pc_out=0, fr_out=0, sp_ovf=sp_unf=0.
- Write X=0xBEEF, then rd_a_sel=1, rd_b_sel=1, rd_a_en=1 → both ports read 0xBEEF. Drop rd_a_en → rd_a_data=Z. rd_b_sel=7 with NUM_REGS=6 → rd_b_data=0.
- PC=0xFFFE, pc_inc for 2 cycles → pc_out 0xFFFF then 0x0000. pc_inc together with wr_sel=5, wr_data=0x0100 → pc_out=0x0100.
- SP: write SP=0x0001, push ×2 → SP 0x0000, then stays 0x0000 with sp_ovf=1. Write SP=0xFFFF → sp_ovf=0. Pop → SP unchanged, sp_unf=1.
- FR: flags_we with flags_in=0xA → fr_out=0xA and rd_b_data(sel 3)=0x000A. Same edge wr_sel=3, wr_data=0x0005 with flags_we, flags_in=0xF → fr_out=0x5.
- Bypass (REGFILE_BYPASS_EN): write Y=0x5555 with rd_b_sel=2 in the same cycle → rd_b_data=0x5555 before the edge. Without the macro → old Y value until after the edge.

Source files
------------

// File: rtl/reg_file_gen_if.sv
// Register-file access bus: write port, two read ports, PC/SP/flag controls, status and register views.
// master = control unit / ALU side, slave = register file.
interface reg_file_gen_if #(
    parameter int DATA_W = 16,
    parameter int FLAG_W = 4,
    parameter int SEL_W  = 3
);
    logic              wr_en;
    logic [SEL_W-1:0]  wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic              rd_a_en;
    logic [SEL_W-1:0]  rd_a_sel;
    wire  [DATA_W-1:0] rd_a_data;
    logic [SEL_W-1:0]  rd_b_sel;
    logic [DATA_W-1:0] rd_b_data;
    logic              pc_inc;
    logic [1:0]        sp_op;
    logic              flags_we;
    logic [FLAG_W-1:0] flags_in;
    logic              sp_ovf;
    logic              sp_unf;
    logic [DATA_W-1:0] acc_out;
    logic [DATA_W-1:0] x_out;
    logic [DATA_W-1:0] y_out;
    logic [DATA_W-1:0] sp_out;
    logic [DATA_W-1:0] pc_out;
    logic [FLAG_W-1:0] fr_out;

    modport master (
        output wr_en, wr_sel, wr_data, rd_a_en, rd_a_sel, rd_b_sel,
               pc_inc, sp_op, flags_we, flags_in,
        input  rd_a_data, rd_b_data, sp_ovf, sp_unf,
               acc_out, x_out, y_out, sp_out, pc_out, fr_out
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, rd_a_en, rd_a_sel, rd_b_sel,
               pc_inc, sp_op, flags_we, flags_in,
        output rd_a_data, rd_b_data, sp_ovf, sp_unf,
               acc_out, x_out, y_out, sp_out, pc_out, fr_out
    );
endinterface

// File: rtl/reg_file_gen.sv
// CPU register file (ACC, X, Y, FR, SP, PC + GP slots): one write port, two combinational read ports,
// PC increment, SP push/pop with sticky ovf/unf, ALU flag path. Macro REGFILE_BYPASS_EN makes reads write-first.
module reg_file_gen #(
    parameter int                 DATA_W   = 16,
    parameter int                 NUM_REGS = 8,
    parameter int                 FLAG_W   = 4,
    parameter logic [DATA_W-1:0]  SP_INIT  = '1,
    parameter logic [DATA_W-1:0]  PC_INIT  = '0,
    parameter int                 SEL_W    = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_gen_if.slave bus
);
    localparam int FR_IDX = 3;
    localparam int SP_IDX = 4;
    localparam int PC_IDX = 5;
    localparam logic [DATA_W-1:0] ALL_ONES = '1;

    logic [DATA_W-1:0] rf      [NUM_REGS];
    logic [DATA_W-1:0] rf_nxt  [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    logic [DATA_W-1:0] wr_fr;
    logic              ovf, unf, ovf_nxt, unf_nxt;
    logic [DATA_W-1:0] rd_a_val, rd_b_val;

    assign wr_fr = DATA_W'(bus.wr_data[FLAG_W-1:0]);

    // Out-of-range write indices match no slot, so such writes are dropped.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_REGS; i++)
            wr_hit[i] = bus.wr_en && (bus.wr_sel == SEL_W'(i));
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            rf_nxt[i] = rf[i];
            if (wr_hit[i])
                rf_nxt[i] = (i == FR_IDX) ? wr_fr : bus.wr_data;
        end
        ovf_nxt = ovf;
        unf_nxt = unf;

        if (!wr_hit[PC_IDX] && bus.pc_inc)
            rf_nxt[PC_IDX] = rf[PC_IDX] + 1'b1;

        if (!wr_hit[FR_IDX] && bus.flags_we)
            rf_nxt[FR_IDX] = DATA_W'(bus.flags_in);

        // An explicit SP write wins over the stack op and clears both sticky flags.
        if (wr_hit[SP_IDX]) begin
            ovf_nxt = 1'b0;
            unf_nxt = 1'b0;
        end else begin
            case (bus.sp_op)
                2'b01: begin
                    if (rf[SP_IDX] != '0) rf_nxt[SP_IDX] = rf[SP_IDX] - 1'b1;
                    else                  ovf_nxt = 1'b1;
                end
                2'b10: begin
                    if (rf[SP_IDX] != ALL_ONES) rf_nxt[SP_IDX] = rf[SP_IDX] + 1'b1;
                    else                        unf_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
            rf[SP_IDX] <= SP_INIT;
            rf[PC_IDX] <= PC_INIT;
            ovf        <= 1'b0;
            unf        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= rf_nxt[i];
            ovf <= ovf_nxt;
            unf <= unf_nxt;
        end
    end

    always_comb begin
        rd_a_val = '0;
        rd_b_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_a_sel == SEL_W'(i)) rd_a_val = rf[i];
            if (bus.rd_b_sel == SEL_W'(i)) rd_b_val = rf[i];
`ifdef REGFILE_BYPASS_EN
            if (wr_hit[i] && bus.rd_a_sel == SEL_W'(i)) rd_a_val = (i == FR_IDX) ? wr_fr : bus.wr_data;
            if (wr_hit[i] && bus.rd_b_sel == SEL_W'(i)) rd_b_val = (i == FR_IDX) ? wr_fr : bus.wr_data;
`endif
        end
    end

    assign bus.rd_a_data = bus.rd_a_en ? rd_a_val : {DATA_W{1'bz}};
    assign bus.rd_b_data = rd_b_val;
    assign bus.sp_ovf    = ovf;
    assign bus.sp_unf    = unf;
    assign bus.acc_out   = rf[0];
    assign bus.x_out     = rf[1];
    assign bus.y_out     = rf[2];
    assign bus.sp_out    = rf[SP_IDX];
    assign bus.pc_out    = rf[PC_IDX];
    assign bus.fr_out    = rf[FR_IDX][FLAG_W-1:0];
endmodule

// File: tb/tb_reg_file_gen.sv
// Directed self-checking bench for reg_file_gen (NUM_REGS=6, DATA_W=16, FLAG_W=4).
module tb_reg_file_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [15:0] zval;

    reg_file_gen_if #(.DATA_W(16), .FLAG_W(4), .SEL_W(3)) bus ();
    reg_file_gen #(.DATA_W(16), .NUM_REGS(6), .FLAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.wr_en = 0; bus.pc_inc = 0; bus.sp_op = 2'b00; bus.flags_we = 0;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [15:0] d);
        bus.wr_en = 1; bus.wr_sel = sel; bus.wr_data = d;
    endtask

    task automatic test_reset;
        wr(3'd0, 16'h1234); bus.sp_op = 2'b10;
        tick; idle;
        checks++; if (bus.acc_out !== 16'h1234) begin errors++; $display("FAIL pre_reset_acc got %h want 1234", bus.acc_out); end
        checks++; if (bus.sp_unf !== 1'b1) begin errors++; $display("FAIL pre_reset_unf got %b want 1", bus.sp_unf); end
        bus.rd_b_sel = 3'd4;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.acc_out !== 16'h0000) begin errors++; $display("FAIL reset_acc got %h want 0000", bus.acc_out); end
        checks++; if (bus.sp_out !== 16'hFFFF) begin errors++; $display("FAIL reset_sp got %h want ffff", bus.sp_out); end
        checks++; if (bus.pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", bus.pc_out); end
        checks++; if (bus.fr_out !== 4'h0) begin errors++; $display("FAIL reset_fr got %h want 0", bus.fr_out); end
        checks++; if ({bus.sp_ovf, bus.sp_unf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {bus.sp_ovf, bus.sp_unf}); end
        checks++; if (bus.rd_b_data !== 16'hFFFF) begin errors++; $display("FAIL reset_rdb_sp got %h want ffff", bus.rd_b_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_ports;
        wr(3'd1, 16'hBEEF);
        tick; idle;
        bus.rd_a_en = 1; bus.rd_a_sel = 3'd1; bus.rd_b_sel = 3'd1;
        #1;
        checks++; if (bus.rd_a_data !== 16'hBEEF) begin errors++; $display("FAIL rd_a_x got %h want beef", bus.rd_a_data); end
        checks++; if (bus.rd_b_data !== 16'hBEEF) begin errors++; $display("FAIL rd_b_x got %h want beef", bus.rd_b_data); end
        bus.rd_a_en = 0;
        #1;
        checks++; if (bus.rd_a_data !== zval) begin errors++; $display("FAIL rd_a_hiz got %h want zzzz", bus.rd_a_data); end
        bus.rd_b_sel = 3'd7;
        #1;
        checks++; if (bus.rd_b_data !== 16'h0000) begin errors++; $display("FAIL rd_b_oob got %h want 0000", bus.rd_b_data); end
        wr(3'd6, 16'hDEAD);
        tick; idle;
        checks++; if ({bus.acc_out, bus.x_out, bus.y_out, bus.sp_out, bus.pc_out} !== {16'h0, 16'hBEEF, 16'h0, 16'hFFFF, 16'h0})
            begin errors++; $display("FAIL wr_oob_ignored got %h %h %h %h %h", bus.acc_out, bus.x_out, bus.y_out, bus.sp_out, bus.pc_out); end
    endtask

    task automatic test_pc;
        wr(3'd5, 16'hFFFE);
        tick; idle;
        bus.pc_inc = 1;
        tick;
        checks++; if (bus.pc_out !== 16'hFFFF) begin errors++; $display("FAIL pc_inc1 got %h want ffff", bus.pc_out); end
        tick;
        checks++; if (bus.pc_out !== 16'h0000) begin errors++; $display("FAIL pc_wrap got %h want 0000", bus.pc_out); end
        wr(3'd5, 16'h0100);
        tick; idle;
        checks++; if (bus.pc_out !== 16'h0100) begin errors++; $display("FAIL pc_wr_prio got %h want 0100", bus.pc_out); end
    endtask

    task automatic test_sp;
        wr(3'd4, 16'h0001);
        tick; idle;
        bus.sp_op = 2'b01;
        tick;
        checks++; if ({bus.sp_out, bus.sp_ovf} !== {16'h0000, 1'b0}) begin errors++; $display("FAIL push1 got %h ovf=%b want 0000 ovf=0", bus.sp_out, bus.sp_ovf); end
        tick;
        checks++; if ({bus.sp_out, bus.sp_ovf} !== {16'h0000, 1'b1}) begin errors++; $display("FAIL push_ovf got %h ovf=%b want 0000 ovf=1", bus.sp_out, bus.sp_ovf); end
        tick;
        checks++; if (bus.sp_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus.sp_ovf); end
        idle; wr(3'd4, 16'hFFFF);
        tick; idle;
        checks++; if ({bus.sp_out, bus.sp_ovf} !== {16'hFFFF, 1'b0}) begin errors++; $display("FAIL sp_wr_clr got %h ovf=%b want ffff ovf=0", bus.sp_out, bus.sp_ovf); end
        bus.sp_op = 2'b10;
        tick;
        checks++; if ({bus.sp_out, bus.sp_unf} !== {16'hFFFF, 1'b1}) begin errors++; $display("FAIL pop_unf got %h unf=%b want ffff unf=1", bus.sp_out, bus.sp_unf); end
        bus.sp_op = 2'b01;
        tick;
        checks++; if ({bus.sp_out, bus.sp_unf} !== {16'hFFFE, 1'b1}) begin errors++; $display("FAIL push_unf_sticky got %h unf=%b want fffe unf=1", bus.sp_out, bus.sp_unf); end
        bus.sp_op = 2'b11;
        tick;
        checks++; if (bus.sp_out !== 16'hFFFE) begin errors++; $display("FAIL sp_op_rsvd got %h want fffe", bus.sp_out); end
        idle; wr(3'd4, 16'h0000);
        tick; idle;
        bus.sp_op = 2'b01; wr(3'd4, 16'h0010);
        tick; idle;
        checks++; if ({bus.sp_out, bus.sp_ovf, bus.sp_unf} !== {16'h0010, 2'b00}) begin errors++; $display("FAIL sp_wr_vs_ovf got %h ovf=%b unf=%b want 0010 0 0", bus.sp_out, bus.sp_ovf, bus.sp_unf); end
    endtask

    task automatic test_flags;
        bus.flags_we = 1; bus.flags_in = 4'hA; bus.rd_b_sel = 3'd3;
        tick; idle;
        checks++; if (bus.fr_out !== 4'hA) begin errors++; $display("FAIL flags_we got %h want a", bus.fr_out); end
        checks++; if (bus.rd_b_data !== 16'h000A) begin errors++; $display("FAIL fr_read_zext got %h want 000a", bus.rd_b_data); end
        bus.flags_we = 1; bus.flags_in = 4'hF; wr(3'd3, 16'hFFF5);
        tick; idle;
        checks++; if (bus.fr_out !== 4'h5) begin errors++; $display("FAIL fr_wr_prio got %h want 5", bus.fr_out); end
        checks++; if (bus.rd_b_data !== 16'h0005) begin errors++; $display("FAIL fr_wr_mask got %h want 0005", bus.rd_b_data); end
    endtask

    task automatic test_concurrent;
        wr(3'd1, 16'h1111); bus.pc_inc = 1; bus.sp_op = 2'b01; bus.flags_we = 1; bus.flags_in = 4'h3;
        tick; idle;
        checks++; if ({bus.x_out, bus.pc_out, bus.sp_out, bus.fr_out} !== {16'h1111, 16'h0101, 16'h000F, 4'h3})
            begin errors++; $display("FAIL concurrent got x=%h pc=%h sp=%h fr=%h want 1111 0101 000f 3", bus.x_out, bus.pc_out, bus.sp_out, bus.fr_out); end
    endtask

    task automatic test_bypass;
        logic [15:0] exp_y, exp_fr;
`ifdef REGFILE_BYPASS_EN
        exp_y = 16'h5555; exp_fr = 16'h0009;
`else
        exp_y = 16'h0000; exp_fr = 16'h0003;
`endif
        wr(3'd2, 16'h5555); bus.rd_b_sel = 3'd2; bus.rd_a_en = 1; bus.rd_a_sel = 3'd2;
        #1;
        checks++; if (bus.rd_b_data !== exp_y) begin errors++; $display("FAIL bypass_b_y got %h want %h", bus.rd_b_data, exp_y); end
        checks++; if (bus.rd_a_data !== exp_y) begin errors++; $display("FAIL bypass_a_y got %h want %h", bus.rd_a_data, exp_y); end
        tick;
        checks++; if (bus.rd_b_data !== 16'h5555) begin errors++; $display("FAIL y_after_edge got %h want 5555", bus.rd_b_data); end
        wr(3'd3, 16'h00C9); bus.rd_b_sel = 3'd3;
        #1;
        checks++; if (bus.rd_b_data !== exp_fr) begin errors++; $display("FAIL bypass_fr got %h want %h", bus.rd_b_data, exp_fr); end
        tick; idle; bus.rd_a_en = 0;
        checks++; if (bus.fr_out !== 4'h9) begin errors++; $display("FAIL fr_after_edge got %h want 9", bus.fr_out); end
    endtask

    initial begin
        zval = {16{1'bz}};
        bus.wr_en = 0; bus.wr_sel = '0; bus.wr_data = '0;
        bus.rd_a_en = 0; bus.rd_a_sel = '0; bus.rd_b_sel = '0;
        bus.pc_inc = 0; bus.sp_op = 2'b00; bus.flags_we = 0; bus.flags_in = '0;
        #12 rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_read_ports;
        test_pc;
        test_sp;
        test_flags;
        test_concurrent;
        test_bypass;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
